// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Imported by the controller top and its performance counters.
package hazard_pkg;

   typedef enum logic [0:0] {
      HZ_RUN,
      HZ_MEM_WAIT
   } hz_state_t;

   localparam logic [4:0] REG_X0 = 5'd0;

   function automatic logic src_match(
      input logic       uses,
      input logic [4:0] rs,
      input logic [4:0] rd
   );
      return uses && (rs == rd);
   endfunction

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter used for stall/flush statistics.
// Holds at all-ones instead of wrapping.
module hazard_perf_counter
   import hazard_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush control for IF/ID, ID/EX, EX/MEM and PC: load-use bubbles,
// taken-redirect flushes and data-memory wait freezes with a timeout.
module hazard_control_unit
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_stall,
   output logic             id_ex_flush,
   output logic             ex_mem_stall,
   output logic             mem_timeout_err,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   localparam int WW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WW-1:0] TMO = WW'(MEM_TIMEOUT);

   hz_state_t     state, state_nxt;
   logic [WW-1:0] wait_cnt, wait_nxt;
   logic          err_set;
   logic          freeze;
   logic          release_now;
   logic          take_br;
   logic          bubble;
   logic          load_use;
   logic          mem_hold;

   assign load_use = ex_mem_read && (ex_rd != REG_X0) &&
                     (src_match(id_uses_rs1, id_rs1, ex_rd) ||
                      src_match(id_uses_rs2, id_rs2, ex_rd));
   assign mem_hold = mem_req && !mem_ready;

   // Redirect wins over the bubble: the dependent instruction is wrong-path.
   assign take_br = ex_branch_taken;
   assign bubble  = load_use && !ex_branch_taken;

   always_comb begin
      state_nxt   = state;
      wait_nxt    = wait_cnt;
      err_set     = 1'b0;
      freeze      = 1'b0;
      release_now = 1'b0;
      unique case (state)
         HZ_RUN: begin
            if (mem_hold) begin
               freeze    = 1'b1;
               state_nxt = HZ_MEM_WAIT;
               wait_nxt  = WW'(1);
            end else begin
               release_now = 1'b1;
            end
         end
         HZ_MEM_WAIT: begin
            if (mem_ready) begin
               release_now = 1'b1;
               state_nxt   = HZ_RUN;
               wait_nxt    = '0;
            end else if (wait_cnt < TMO) begin
               freeze   = 1'b1;
               wait_nxt = wait_cnt + 1'b1;
            end else begin
               err_set     = 1'b1;
               release_now = 1'b1;
               state_nxt   = HZ_RUN;
               wait_nxt    = '0;
            end
         end
         default: begin
            state_nxt = HZ_RUN;
            wait_nxt  = '0;
         end
      endcase
   end

   always_comb begin
      pc_write     = 1'b0;
      if_id_stall  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_stall  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_stall = 1'b0;
      if (!rst) begin
         if (freeze) begin
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
         end else if (release_now) begin
            unique case (1'b1)
               take_br: begin
                  pc_write    = 1'b1;
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
               end
               bubble: begin
                  if_id_stall = 1'b1;
                  id_ex_flush = 1'b1;
               end
               default: pc_write = 1'b1;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= HZ_RUN;
         wait_cnt        <= '0;
         mem_timeout_err <= 1'b0;
      end else begin
         state           <= state_nxt;
         wait_cnt        <= wait_nxt;
         mem_timeout_err <= mem_timeout_err | err_set;
      end
   end

   hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (!pc_write),
      .cnt (stall_cycles)
   );

   hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .inc (release_now && take_br),
      .cnt (flush_events)
   );

endmodule
